// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780 4-bit text LCD controller with command stream
module lcd_text_ctrl #(
  parameter int CLOCK_RATE    = 1000,
  parameter int ROWS          = 2,
  parameter int COLS          = 16,
  parameter int INIT_DELAY_MS = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  input  logic [1:0] cmd_row,
  input  logic [5:0] cmd_col,
  output logic       init_done,
  output logic       en,
  output logic       rs,
  output logic [3:0] data
);

  localparam int DIV = CLOCK_RATE / 1000;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WW  = (INIT_DELAY_MS > 5) ? $clog2(INIT_DELAY_MS + 1) : 3;

  localparam logic [1:0] T_CHAR  = 2'd0;
  localparam logic [1:0] T_GOTO  = 2'd1;
  localparam logic [1:0] T_CLEAR = 2'd2;
  localparam logic [1:0] T_RAW   = 2'd3;

  localparam logic [1:0] ROW_MAX = 2'(ROWS - 1);
  localparam logic [5:0] COL_MAX = 6'(COLS - 1);

  typedef enum logic [2:0] {
    INIT_WAIT, INIT_NIB, INIT_BYTES, IDLE, SET_ADDR, SEND_BYTE, POST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    idx_q, idx_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  logic [1:0]    cmd_type_q;
  logic [7:0]    byte_q;
  logic          rs_q;
  logic          post_q;
  logic [1:0]    cur_row;
  logic [5:0]    cur_col;
  logic          pend;

  logic          accept;
  logic          byte_done;
  logic          post_done;
  logic [7:0]    out_byte;
  logic          out_rs;
  logic [WW-1:0] nib_wait;
  logic [6:0]    row_base;
  logic [6:0]    addr;
  logic [1:0]    row_clamped;
  logic [5:0]    col_clamped;

  assign tick = (tick_cnt == TW'(DIV - 1));

  // Row base addresses, DDRAM address of the cursor, and goto clamping
  always_comb begin
    row_base = 7'h00;
    case (cur_row)
      2'd0:    row_base = 7'h00;
      2'd1:    row_base = 7'h40;
      2'd2:    row_base = 7'h14;
      default: row_base = 7'h54;
    endcase
    addr        = row_base + {1'b0, cur_col};
    row_clamped = (cmd_row > ROW_MAX) ? ROW_MAX : cmd_row;
    col_clamped = (cmd_col > COL_MAX) ? COL_MAX : cmd_col;
  end

  // 1 ms tick divider; restarted on accept so the first nibble phase spans a full tick
  always_ff @(posedge clk) begin
    if (reset || accept || tick) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + TW'(1);
  end

  // FSM state and sequencing counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT_WAIT;
      phase_q <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state, LCD pin drive and handshake
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    byte_done = 1'b0;
    post_done = 1'b0;
    en        = 1'b0;
    rs        = 1'b0;
    data      = 4'h0;
    cmd_ready = (state_q == IDLE) && init_done;
    accept    = cmd_ready && cmd_valid;
    nib_wait  = (idx_q == 2'd3) ? WW'(0) : (idx_q == 2'd2) ? WW'(1) : WW'(5);

    out_byte = byte_q;
    out_rs   = rs_q;
    if (state_q == INIT_BYTES) begin
      out_rs = 1'b0;
      case (idx_q)
        2'd0:    out_byte = 8'h28;
        2'd1:    out_byte = 8'h0C;
        2'd2:    out_byte = 8'h06;
        default: out_byte = 8'h01;
      endcase
    end else if (state_q == SET_ADDR) begin
      out_rs   = 1'b0;
      out_byte = {1'b1, addr};
    end

    case (state_q)
      INIT_WAIT: begin
        if (tick) begin
          if (wcnt_q == WW'(INIT_DELAY_MS - 1)) begin
            state_d = INIT_NIB;
            wcnt_d  = '0;
            phase_d = '0;
            idx_d   = '0;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      INIT_NIB: begin
        // phase 0: en high, phase 1: en low, phase 2: post-nibble wait
        data = (idx_q == 2'd3) ? 4'h2 : 4'h3;
        en   = (phase_q == 2'd0);
        if (tick) begin
          if (phase_q == 2'd0) begin
            phase_d = 2'd1;
          end else if (phase_q == 2'd1 && nib_wait != '0) begin
            phase_d = 2'd2;
            wcnt_d  = '0;
          end else if (phase_q == 2'd2 && wcnt_q != nib_wait - WW'(1)) begin
            wcnt_d = wcnt_q + WW'(1);
          end else begin
            phase_d = '0;
            wcnt_d  = '0;
            if (idx_q == 2'd3) begin
              state_d = INIT_BYTES;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end
      INIT_BYTES, SET_ADDR, SEND_BYTE: begin
        en   = ~phase_q[0];
        rs   = out_rs;
        data = phase_q[1] ? out_byte[3:0] : out_byte[7:4];
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            byte_done = 1'b1;
            wcnt_d    = '0;
            case (state_q)
              INIT_BYTES: begin
                if (idx_q == 2'd3) state_d = POST_WAIT;
                else               idx_d   = idx_q + 2'd1;
              end
              SET_ADDR: state_d = (cmd_type_q == T_CHAR) ? SEND_BYTE : IDLE;
              default:  state_d = post_q ? POST_WAIT : IDLE;
            endcase
          end
        end
      end
      POST_WAIT: begin
        if (tick) begin
          if (wcnt_q == WW'(1)) begin
            post_done = 1'b1;
            state_d   = IDLE;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      IDLE: begin
        if (accept) begin
          phase_d = '0;
          case (cmd_type)
            T_CHAR:  state_d = pend ? SET_ADDR : SEND_BYTE;
            T_GOTO:  state_d = SET_ADDR;
            default: state_d = SEND_BYTE;
          endcase
        end
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  // Command registers, cursor tracking and the sticky init flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_type_q <= T_CHAR;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      post_q     <= 1'b0;
      cur_row    <= '0;
      cur_col    <= '0;
      pend       <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      if (accept) begin
        cmd_type_q <= cmd_type;
        case (cmd_type)
          T_CHAR: begin
            byte_q <= cmd_data;
            rs_q   <= 1'b1;
            post_q <= 1'b0;
          end
          T_GOTO: begin
            cur_row <= row_clamped;
            cur_col <= col_clamped;
            pend    <= 1'b0;
            rs_q    <= 1'b0;
            post_q  <= 1'b0;
          end
          T_CLEAR: begin
            byte_q <= 8'h01;
            rs_q   <= 1'b0;
            post_q <= 1'b1;
          end
          default: begin
            byte_q <= cmd_data;
            rs_q   <= 1'b0;
            post_q <= (cmd_data == 8'h01) || (cmd_data == 8'h02);
          end
        endcase
      end
      if (state_q == SET_ADDR && byte_done) pend <= 1'b0;
      if (state_q == SEND_BYTE && byte_done && cmd_type_q == T_CHAR) begin
        if (cur_col == COL_MAX) begin
          cur_col <= '0;
          cur_row <= (cur_row == ROW_MAX) ? 2'd0 : cur_row + 2'd1;
          pend    <= 1'b1;
        end else begin
          cur_col <= cur_col + 6'd1;
        end
      end
      // Init, clear and home all finish through POST_WAIT with the LCD at address 0
      if (post_done) begin
        init_done <= 1'b1;
        cur_row   <= '0;
        cur_col   <= '0;
        pend      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb/tb_lcd_text_ctrl.sv - directed testbench for lcd_text_ctrl
module tb_lcd_text_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [1:0] cmd_row = 2'd0;
  logic [5:0] cmd_col = 6'd0;
  logic       init_done, en, rs;
  logic [3:0] data;

  logic       f_cmd_valid = 1'b0;
  logic       f_cmd_ready;
  logic [1:0] f_cmd_type = 2'd0;
  logic [7:0] f_cmd_data = 8'd0;
  logic       f_init_done, f_en, f_rs;
  logic [3:0] f_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [4:0] nibq[$];
  int         rise_q[$];
  int         f_len[$];
  logic       en_d = 1'b0;
  int         f_hi = 0;

  typedef struct {
    logic [1:0] ctype;
    logic [7:0] cdata;
    logic [1:0] crow;
    logic [5:0] ccol;
    int         n;
    logic [4:0] nib [4];
    int         busy;
  } cmd_t;

  cmd_t tbl [14];

  lcd_text_ctrl #(.CLOCK_RATE(1000), .ROWS(2), .COLS(16), .INIT_DELAY_MS(40)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .init_done(init_done), .en(en), .rs(rs), .data(data)
  );

  lcd_text_ctrl #(.CLOCK_RATE(4000), .ROWS(2), .COLS(16), .INIT_DELAY_MS(2)) u_fast (
    .clk(clk), .reset(reset), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_type(f_cmd_type), .cmd_data(f_cmd_data), .cmd_row(2'd0), .cmd_col(6'd0),
    .init_done(f_init_done), .en(f_en), .rs(f_rs), .data(f_data)
  );

  always #5 clk = ~clk;

  // cycle 1 is the cycle following the last reset edge
  always @(posedge clk) begin
    if (reset) cyc <= 1;
    else       cyc <= cyc + 1;
  end

  // record each en rising edge with its rs/data and cycle number
  always @(negedge clk) begin
    if (en && !en_d) begin
      nibq.push_back({rs, data});
      rise_q.push_back(cyc);
    end
    en_d <= en;
  end

  // record the length of each en high pulse on the fast instance
  always @(negedge clk) begin
    if (f_en) begin
      f_hi <= f_hi + 1;
    end else begin
      if (f_hi != 0) f_len.push_back(f_hi);
      f_hi <= 0;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] t, input logic [7:0] d, input logic [1:0] r,
                              input logic [5:0] c, input int n, input logic [4:0] n0,
                              input logic [4:0] n1, input logic [4:0] n2, input logic [4:0] n3,
                              input int busy);
    cmd_t x;
    x.ctype = t; x.cdata = d; x.crow = r; x.ccol = c; x.n = n;
    x.nib[0] = n0; x.nib[1] = n1; x.nib[2] = n2; x.nib[3] = n3;
    x.busy = busy;
    return x;
  endfunction

  // offer one command, then scramble the inputs and check busy time and nibbles
  task automatic send(input cmd_t c, input string name);
    int n;
    int busy;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({name, " ready"}, int'(cmd_ready), 1);
    nibq.delete();
    cmd_type  = c.ctype;
    cmd_data  = c.cdata;
    cmd_row   = c.crow;
    cmd_col   = c.ccol;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_data  = 8'($urandom);
    cmd_row   = 2'($urandom);
    cmd_col   = 6'($urandom);
    busy = 0;
    while (cmd_ready !== 1'b1 && busy < 100) begin busy++; @(negedge clk); end
    check({name, " busy"}, busy, c.busy);
    check({name, " nibbles"}, nibq.size(), c.n);
    for (int i = 0; i < c.n && i < nibq.size(); i++)
      check($sformatf("%s nib%0d", name, i), int'(nibq[i]), int'(c.nib[i]));
  endtask

  // wait for init_done and check its timing and the init nibble sequence
  task automatic check_init(input string name);
    int n;
    int exp_init [12];
    exp_init = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 6, 0, 1};
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check({name, " init_done"}, int'(init_done), 1);
    check({name, " init_done cycle"}, cyc, 78);
    check({name, " ready with init_done"}, int'(cmd_ready), 1);
    check({name, " init nibble count"}, nibq.size(), 12);
    for (int i = 0; i < 12 && i < nibq.size(); i++)
      check($sformatf("%s init nib%0d", name, i), int'(nibq[i]), exp_init[i]);
    if (rise_q.size() > 0) check({name, " first en cycle"}, rise_q[0], 41);
    else                   check({name, " first en cycle"}, 0, 41);
  endtask

  initial begin
    int n;
    int viol;
    cmd_t r;
    logic [7:0] code;
    int k;

    // char, goto, clear, raw commands with rs in bit 4 of each nibble entry
    tbl[0]  = mk(2'd0, 8'h41, 2'd0, 6'd0,  2, 5'h14, 5'h11, 5'h00, 5'h00, 4);
    tbl[1]  = mk(2'd1, 8'h00, 2'd3, 6'd50, 2, 5'h0C, 5'h0F, 5'h00, 5'h00, 4);
    tbl[2]  = mk(2'd0, 8'h42, 2'd0, 6'd0,  2, 5'h14, 5'h12, 5'h00, 5'h00, 4);
    tbl[3]  = mk(2'd0, 8'h43, 2'd0, 6'd0,  4, 5'h08, 5'h00, 5'h14, 5'h13, 8);
    tbl[4]  = mk(2'd2, 8'h00, 2'd0, 6'd0,  2, 5'h00, 5'h01, 5'h00, 5'h00, 6);
    tbl[5]  = mk(2'd0, 8'h44, 2'd0, 6'd0,  2, 5'h14, 5'h14, 5'h00, 5'h00, 4);
    tbl[6]  = mk(2'd3, 8'h0F, 2'd0, 6'd0,  2, 5'h00, 5'h0F, 5'h00, 5'h00, 4);
    tbl[7]  = mk(2'd1, 8'h00, 2'd1, 6'd3,  2, 5'h0C, 5'h03, 5'h00, 5'h00, 4);
    tbl[8]  = mk(2'd3, 8'h02, 2'd0, 6'd0,  2, 5'h00, 5'h02, 5'h00, 5'h00, 6);
    tbl[9]  = mk(2'd0, 8'h45, 2'd0, 6'd0,  2, 5'h14, 5'h15, 5'h00, 5'h00, 4);
    tbl[10] = mk(2'd1, 8'h00, 2'd0, 6'd16, 2, 5'h08, 5'h0F, 5'h00, 5'h00, 4);
    tbl[11] = mk(2'd0, 8'h46, 2'd0, 6'd0,  2, 5'h14, 5'h16, 5'h00, 5'h00, 4);
    tbl[12] = mk(2'd0, 8'h47, 2'd0, 6'd0,  4, 5'h0C, 5'h00, 5'h14, 5'h17, 8);
    tbl[13] = mk(2'd3, 8'h01, 2'd0, 6'd0,  2, 5'h00, 5'h01, 5'h00, 5'h00, 6);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset en", int'(en), 0);
    check("reset rs", int'(rs), 0);
    check("reset data", int'(data), 0);
    check("reset cmd_ready", int'(cmd_ready), 0);
    check("reset init_done", int'(init_done), 0);
    check("reset fast en", int'(f_en), 0);
    reset = 1'b0;
    nibq.delete();
    rise_q.delete();
    f_len.delete();

    check_init("boot");

    // fast clock: every en pulse spans 4 clocks, including one accepted off-tick
    n = 0;
    while (f_init_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    check("fast init_done", int'(f_init_done), 1);
    check("fast init pulse count", f_len.size(), 12);
    for (int i = 0; i < f_len.size(); i++)
      check($sformatf("fast init pulse%0d width", i), f_len[i], 4);
    @(negedge clk);
    f_len.delete();
    f_cmd_type  = 2'd0;
    f_cmd_data  = 8'h41;
    f_cmd_valid = 1'b1;
    @(negedge clk);
    f_cmd_valid = 1'b0;
    n = 0;
    while (f_cmd_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    check("fast char busy", n, 16);
    check("fast char pulse count", f_len.size(), 2);
    for (int i = 0; i < f_len.size(); i++)
      check($sformatf("fast char pulse%0d width", i), f_len[i], 4);

    for (int i = 0; i < 14; i++)
      send(tbl[i], $sformatf("tbl%0d", i));

    // 33 chars from (0,0): row 1 address before the 17th, row 0 before the 33rd
    for (int i = 0; i < 33; i++) begin
      code = 8'h30 + 8'(i);
      r = mk(2'd0, code, 2'd0, 6'd0, 2, 5'h00, 5'h00, 5'h00, 5'h00, 4);
      k = 0;
      if (i == 16) begin r.nib[0] = 5'h0C; r.nib[1] = 5'h00; k = 2; end
      if (i == 32) begin r.nib[0] = 5'h08; r.nib[1] = 5'h00; k = 2; end
      r.nib[k]     = {1'b1, code[7:4]};
      r.nib[k + 1] = {1'b1, code[3:0]};
      r.n    = k + 2;
      r.busy = (k != 0) ? 8 : 4;
      send(r, $sformatf("wrap%0d", i));
    end

    // reset mid-byte with cmd_valid held until init completes
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    cmd_type  = 2'd0;
    cmd_data  = 8'h5A;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("midreset en high", int'(en), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset en", int'(en), 0);
    check("midreset ready", int'(cmd_ready), 0);
    check("midreset init_done", int'(init_done), 0);
    reset = 1'b0;
    nibq.delete();
    rise_q.delete();
    viol = 0;
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin
      if (cmd_ready) viol++;
      @(negedge clk);
      n++;
    end
    check("midreset ready during init", viol, 0);
    check_init("midreset");
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("held char busy", n, 4);
    check("held char nibbles", nibq.size(), 14);
    if (nibq.size() >= 14) begin
      check("held char hi", int'(nibq[12]), 'h15);
      check("held char lo", int'(nibq[13]), 'h1A);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
